// File: rtl/led_pkg.sv
// Shared definitions for the LED chaser: mode encodings and bounce direction.
package led_pkg;

    localparam logic [1:0] MODE_ROL    = 2'd0;
    localparam logic [1:0] MODE_ROR    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_t;

endpackage

// File: rtl/led_tick_div.sv
// Programmable prescaler: emits a combinational tick once every div cycles
// (div of 0 behaves like 1). Holds while pause is high.
module led_tick_div #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             pause,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    // Terminal count; the >= compare lets a lowered div wrap on the next cycle.
    always_comb begin
        last = (div == '0) ? '0 : (div - ONE);
        tick = !pause && (cnt >= last);
    end

    // Counter advances or wraps only while not paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!pause) begin
            if (cnt >= last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/led_chaser.sv
// LED pattern generator: rotate left/right, bounce or blink, one step per
// prescaler tick. Optional PWM dimming is enabled with macro LED_PWM_DIM_EN.
module led_chaser
    import led_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             pause,
    input  logic [3:0]       brightness,
    output logic             step,
    output logic [WIDTH-1:0] led_out
);

    localparam logic [WIDTH-1:0] SEED = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic             tick;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] pattern_nxt;
    dir_t             dir;
    dir_t             dir_nxt;
    logic [1:0]       mode_q;
    logic [1:0]       mode_nxt;

    led_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk   (clk),
        .rst   (rst),
        .div   (div),
        .pause (pause),
        .tick  (tick)
    );

    // Next pattern: a mode change or a dead all-zero pattern reloads the seed
    // instead of advancing; otherwise step according to the latched mode.
    always_comb begin
        pattern_nxt = pattern;
        dir_nxt     = dir;
        mode_nxt    = mode_q;
        if (tick) begin
            if (mode != mode_q) begin
                mode_nxt    = mode;
                pattern_nxt = (mode == MODE_BLINK) ? ONES : SEED;
                dir_nxt     = DIR_L;
            end else if ((mode_q != MODE_BLINK) && (pattern == '0)) begin
                pattern_nxt = SEED;
                dir_nxt     = DIR_L;
            end else begin
                case (mode_q)
                    MODE_ROL: pattern_nxt = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
                    MODE_ROR: pattern_nxt = {pattern[0], pattern[WIDTH-1:1]};
                    MODE_BOUNCE: begin
                        if (dir == DIR_L) begin
                            if (pattern[WIDTH-1]) begin
                                dir_nxt     = DIR_R;
                                pattern_nxt = pattern >> 1;
                            end else begin
                                pattern_nxt = pattern << 1;
                            end
                        end else begin
                            if (pattern[0]) begin
                                dir_nxt     = DIR_L;
                                pattern_nxt = pattern << 1;
                            end else begin
                                pattern_nxt = pattern >> 1;
                            end
                        end
                    end
                    default: pattern_nxt = ~pattern;
                endcase
            end
        end
    end

    // Pattern state register; step mirrors the tick one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= SEED;
            dir     <= DIR_L;
            mode_q  <= MODE_ROL;
            step    <= 1'b0;
        end else begin
            pattern <= pattern_nxt;
            dir     <= dir_nxt;
            mode_q  <= mode_nxt;
            step    <= tick;
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [3:0] pwm_cnt;

    // Free-running PWM phase, deliberately not stopped by pause.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign led_out = pattern & {WIDTH{pwm_cnt < brightness}};
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign led_out = pattern;
`endif

endmodule

// File: tb/tb_led_chaser.sv
// Directed self-checking bench for led_chaser. A 16-LED instance covers most
// behaviour; a 4-LED instance sharing the same inputs covers bounce.
module tb_led_chaser;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [31:0] div;
    logic        pause;
    logic [3:0]  brightness;
    logic        step16;
    logic [15:0] led16;
    logic        step4;
    logic [3:0]  led4;

    int vectors    = 0;
    int miscompares = 0;

    led_chaser #(.WIDTH(16), .DIV_W(32)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .div        (div),
        .pause      (pause),
        .brightness (brightness),
        .step       (step16),
        .led_out    (led16)
    );

    led_chaser #(.WIDTH(4), .DIV_W(32)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .div        (div),
        .pause      (pause),
        .brightness (brightness),
        .step       (step4),
        .led_out    (led4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic [1:0] m, input logic [31:0] d,
                                 input logic p, input logic [3:0] b);
        rst        = r;
        mode       = m;
        div        = d;
        pause      = p;
        brightness = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [15:0] exp16;
        int          bseq[8];
        int          lit;
        int          extra;
        bseq = '{0, 1, 2, 3, 2, 1, 0, 1};

        // Reset state, then rotate left with div=3
        applyStimulus(1'b1, 2'd0, 32'd3, 1'b0, 4'd15);
        cycles(2);
        checkOutput("reset_led", 32'(led16), 32'h0001);
        checkOutput("reset_step", 32'(step16), 32'd0);
        applyStimulus(1'b0, 2'd0, 32'd3, 1'b0, 4'd15);
        cycles(2);
        checkOutput("rol_prestep", 32'(step16), 32'd0);
        checkOutput("rol_prestep_led", 32'(led16), 32'h0001);
        cycles(1);
        checkOutput("rol_step1", 32'(step16), 32'd1);
        checkOutput("rol_led1", 32'(led16), 32'h0002);
        exp16 = 16'h0002;
        for (int k = 2; k <= 16; k++) begin
            cycles(1);
            checkOutput("rol_gap", 32'(step16), 32'd0);
            cycles(2);
            exp16 = {exp16[14:0], exp16[15]};
            checkOutput("rol_step", 32'(step16), 32'd1);
            checkOutput("rol_led", 32'(led16), 32'(exp16));
        end
        checkOutput("rol_after16", 32'(led16), 32'h0001);

        // Rotate right, div=1: first tick is a reload
        applyStimulus(1'b1, 2'd1, 32'd1, 1'b0, 4'd15);
        cycles(2);
        applyStimulus(1'b0, 2'd1, 32'd1, 1'b0, 4'd15);
        cycles(1);
        checkOutput("ror_reload_step", 32'(step16), 32'd1);
        checkOutput("ror_reload_led", 32'(led16), 32'h0001);
        cycles(1);
        checkOutput("ror_step2", 32'(step16), 32'd1);
        checkOutput("ror_led2", 32'(led16), 32'h8000);
        cycles(1);
        checkOutput("ror_led3", 32'(led16), 32'h4000);

        // Bounce on the 4-LED instance
        applyStimulus(1'b1, 2'd2, 32'd1, 1'b0, 4'd15);
        cycles(2);
        applyStimulus(1'b0, 2'd2, 32'd1, 1'b0, 4'd15);
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            checkOutput("bounce_led", 32'(led4), 32'(1) << bseq[i]);
            checkOutput("bounce_step", 32'(step4), 32'd1);
        end

        // Mode change 0->3 mid-interval with div=4
        applyStimulus(1'b1, 2'd0, 32'd4, 1'b0, 4'd15);
        cycles(2);
        applyStimulus(1'b0, 2'd0, 32'd4, 1'b0, 4'd15);
        cycles(1);
        applyStimulus(1'b0, 2'd3, 32'd4, 1'b0, 4'd15);
        cycles(1);
        checkOutput("chg_hold_led", 32'(led16), 32'h0001);
        checkOutput("chg_hold_step", 32'(step16), 32'd0);
        cycles(1);
        checkOutput("chg_hold2_led", 32'(led16), 32'h0001);
        checkOutput("chg_hold2_step", 32'(step16), 32'd0);
        cycles(1);
        checkOutput("chg_tick_led", 32'(led16), 32'hFFFF);
        checkOutput("chg_tick_step", 32'(step16), 32'd1);
        cycles(3);
        checkOutput("blink_wait_step", 32'(step16), 32'd0);
        checkOutput("blink_wait_led", 32'(led16), 32'hFFFF);
        cycles(1);
        checkOutput("blink_led", 32'(led16), 32'h0000);
        checkOutput("blink_step", 32'(step16), 32'd1);

        // Pause mid-count with div=5, then resume and lower div
        applyStimulus(1'b1, 2'd0, 32'd5, 1'b0, 4'd15);
        cycles(2);
        applyStimulus(1'b0, 2'd0, 32'd5, 1'b0, 4'd15);
        cycles(2);
        applyStimulus(1'b0, 2'd0, 32'd5, 1'b1, 4'd15);
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            checkOutput("pause_step", 32'(step16), 32'd0);
            checkOutput("pause_led", 32'(led16), 32'h0001);
        end
        applyStimulus(1'b0, 2'd0, 32'd5, 1'b0, 4'd15);
        cycles(2);
        checkOutput("resume_nostep", 32'(step16), 32'd0);
        cycles(1);
        checkOutput("resume_step", 32'(step16), 32'd1);
        checkOutput("resume_led", 32'(led16), 32'h0002);
        cycles(4);
        checkOutput("div5_cnt4_step", 32'(step16), 32'd0);
        applyStimulus(1'b0, 2'd0, 32'd2, 1'b0, 4'd15);
        cycles(1);
        checkOutput("div_lower_step", 32'(step16), 32'd1);
        checkOutput("div_lower_led", 32'(led16), 32'h0004);
        cycles(1);
        checkOutput("div2_gap", 32'(step16), 32'd0);
        cycles(1);
        checkOutput("div2_step", 32'(step16), 32'd1);
        checkOutput("div2_led", 32'(led16), 32'h0008);

        // div=0 behaves as div=1
        applyStimulus(1'b1, 2'd0, 32'd0, 1'b0, 4'd15);
        cycles(2);
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 4'd15);
        cycles(1);
        checkOutput("div0_step1", 32'(step16), 32'd1);
        checkOutput("div0_led1", 32'(led16), 32'h0002);
        cycles(1);
        checkOutput("div0_step2", 32'(step16), 32'd1);
        checkOutput("div0_led2", 32'(led16), 32'h0004);

        // Dimming with the pattern frozen by pause
        applyStimulus(1'b1, 2'd0, 32'd1, 1'b1, 4'd4);
        cycles(2);
        applyStimulus(1'b0, 2'd0, 32'd1, 1'b1, 4'd4);
        lit   = 0;
        extra = 0;
        for (int i = 0; i < 16; i++) begin
            cycles(1);
            if (led16[0]) lit++;
            if ((led16 & 16'hFFFE) != 16'h0000) extra++;
            if (step16) extra++;
        end
`ifdef LED_PWM_DIM_EN
        checkOutput("pwm_b4_lit", 32'(lit), 32'd4);
`else
        checkOutput("pwm_b4_lit", 32'(lit), 32'd16);
`endif
        checkOutput("pwm_b4_other", 32'(extra), 32'd0);
        applyStimulus(1'b0, 2'd0, 32'd1, 1'b1, 4'd0);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            cycles(1);
            if (led16 != 16'h0000) lit++;
        end
`ifdef LED_PWM_DIM_EN
        checkOutput("pwm_b0_lit", 32'(lit), 32'd0);
`else
        checkOutput("pwm_b0_lit", 32'(lit), 32'd16);
`endif

        // Reset mid-run takes effect on the next edge
        applyStimulus(1'b0, 2'd0, 32'd1, 1'b0, 4'd15);
        cycles(5);
        checkOutput("run_before_rst", 32'(led16), 32'h0020);
        applyStimulus(1'b1, 2'd0, 32'd1, 1'b0, 4'd15);
        cycles(1);
        checkOutput("midrst_led", 32'(led16), 32'h0001);
        checkOutput("midrst_step", 32'(step16), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
